instr_fetch_unit: RTL and testbench

//  Fetch stage of the LEGv8 core: owns the PC, issues reads to instruction memory and presents
//  one instruction + its PC to decode, which feeds the sign extender. Applies branch redirects

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/branch_target_calc.sv | 16 +
 rtl/instr_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 fetch stage.
//  - Word and instruction widths. The guards let a common defines file set them first.
//  - fetch_state_t: the fetch FSM state encoding.
//  - PC_STEP / BR_SHIFT: sequential PC increment and branch offset scaling.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package fetch_pkg;

  localparam int WORD_W  = `WORD;
  localparam int INSTR_W = `INSTR_LEN;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, DRAIN} fetch_state_t;

  localparam logic [WORD_W-1:0] PC_STEP  = WORD_W'(4);
  localparam int                BR_SHIFT = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours.
//  imem_*   : instruction memory read channel (single outstanding request)
//  instr_*  : valid/ready handshake carrying instruction + PC toward decode
//  branch_* : redirect request from the branch resolution logic
// Modports: master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [WORD_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [WORD_W-1:0]  pc_out;

  logic               branch_taken;
  logic [WORD_W-1:0]  branch_pc;
  logic [WORD_W-1:0]  branch_offset;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_pc, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_pc, branch_offset
  );

endinterface

// File: rtl/branch_target_calc.sv
// Branch target adder: target = branch_pc + (branch_offset << BR_SHIFT).
// Purely combinational; modulo 2^WORD, the shift drops the top offset bits.
//  branch_pc_i     in   WORD   PC of the resolving branch
//  branch_offset_i in   WORD   sign-extended word offset
//  target_o        out  WORD   byte address of the branch target
module branch_target_calc
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] branch_pc_i,
  input  logic [WORD_W-1:0] branch_offset_i,
  output logic [WORD_W-1:0] target_o
);

  assign target_o = branch_pc_i + (branch_offset_i << BR_SHIFT);

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, issues single-outstanding reads to instruction
// memory and hands one instruction + PC at a time to decode. Branch redirects
// replace the PC with branch_pc + (branch_offset << 2).
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  bus (master)        imem read channel, decode handshake, branch redirect
//  fetch_cnt/stall_cnt only with FETCH_PERF_CNT_EN defined: completed
//                      handshakes and stalled cycles (valid && !ready)
//
// state | meaning
// IDLE  | out of reset, start fetching next cycle
// REQ   | imem_req asserted for pc this cycle
// WAIT  | request outstanding, waiting for imem_rvalid
// VALID | instruction presented to decode, waiting for handshake
// DRAIN | redirected with a request in flight; discard its response
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0]   fetch_cnt,
  output logic [WORD_W-1:0]   stall_cnt
`endif
);

  fetch_state_t       state_q, state_d;
  logic [WORD_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0]  pc_out_q, pc_out_d;
  logic               squash_q, squash_d;

  logic [WORD_W-1:0]  target;
  logic               handshake;
  logic               redirect;

  branch_target_calc u_btc (
    .branch_pc_i     (bus.branch_pc),
    .branch_offset_i (bus.branch_offset),
    .target_o        (target)
  );

  assign handshake = valid_q && bus.instr_ready;
  assign redirect  = bus.branch_taken && (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = 1'b0;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    squash_d = squash_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d  = bus.imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = VALID;
        end
      end
      VALID: begin
        if (handshake) begin
          valid_d = 1'b0;
          pc_d    = pc_q + PC_STEP;
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      DRAIN: begin
        // squash_q is always set in DRAIN; clearing it marks the stale reply consumed
        if (bus.imem_rvalid || !squash_q) begin
          squash_d = 1'b0;
          state_d  = REQ;
          req_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides the sequential update; a coincident handshake still
    // consumed the presented instruction, only the pc+4 is dropped.
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
      case (state_q)
        WAIT: begin
          instr_d  = instr_q;
          pc_out_d = pc_out_q;
          if (bus.imem_rvalid) begin
            // stale response is arriving right now: nothing left in flight
            squash_d = 1'b0;
            state_d  = REQ;
            req_d    = 1'b1;
          end else begin
            squash_d = 1'b1;
            state_d  = DRAIN;
          end
        end
        REQ: begin
          if (req_q) begin
            // request leaves this cycle, so its response must be drained
            squash_d = 1'b1;
            state_d  = DRAIN;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
        VALID: begin
          state_d = REQ;
          req_d   = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      squash_q <= squash_d;
    end
  end

  // imem_addr tracks the PC register directly, so it is registered and
  // equals RESET_PC out of reset.
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [WORD_W-1:0] CNT_ONE = WORD_W'(1);

  logic [WORD_W-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handshake) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_ONE;
      end
      if (valid_q && !bus.instr_ready) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int W = WORD_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [W-1:0] fetch_cnt, stall_cnt;
`endif

  instr_fetch_unit #(.RESET_PC('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic verify(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic final_result();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  function automatic logic [31:0] instr_of(input logic [W-1:0] a);
    return 32'hD000_0000 ^ a[31:0];
  endfunction

  // ---------------- behavioural imem (latency in cycles, captured per request)
  int          lat  = 1;
  int          cnt  = 0;
  logic        pend = 1'b0;
  logic [31:0] dat  = '0;

  always @(posedge clk) begin
    bus.imem_rvalid <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= dat;
        pend            <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (bus.imem_req === 1'b1) begin
      if (lat <= 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= instr_of(bus.imem_addr);
      end else begin
        pend <= 1'b1;
        cnt  <= lat - 1;
        dat  <= instr_of(bus.imem_addr);
      end
    end
  end

  // ---------------- scoreboard
  logic [W-1:0] exp_addr_q[$];
  logic [W-1:0] exp_pc_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %0h with no request expected", bus.imem_addr);
        end else begin
          verify("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
        end
      end
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        if (exp_pc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: pc_out %0h with no delivery expected", bus.pc_out);
        end else begin
          logic [W-1:0] p;
          p = exp_pc_q.pop_front();
          verify("pc_out", bus.pc_out, p);
          verify("instr_out", W'(bus.instr_out), W'(instr_of(p)));
        end
      end
    end
  end

  // ---------------- stimulus helpers (drive/observe 1 time unit after posedge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [W-1:0] pc, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.instr_valid === 1'b1 && bus.pc_out === pc) && n < budget);
    checks++;
    if (!(bus.instr_valid === 1'b1 && bus.pc_out === pc)) begin
      errors++;
      $display("FAIL wait_valid: no instr_valid for pc %0h within %0d cycles", pc, budget);
    end
  endtask

  task automatic wait_req(input logic [W-1:0] addr, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.imem_req === 1'b1 && bus.imem_addr === addr) && n < budget);
    checks++;
    if (!(bus.imem_req === 1'b1 && bus.imem_addr === addr)) begin
      errors++;
      $display("FAIL wait_req: no imem_req for %0h within %0d cycles", addr, budget);
    end
  endtask

  task automatic pulse_branch(input logic [W-1:0] bpc, input logic [W-1:0] off);
    bus.branch_pc     = bpc;
    bus.branch_offset = off;
    bus.branch_taken  = 1'b1;
    tick();
    bus.branch_taken  = 1'b0;
  endtask

  task automatic measure_latency();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.instr_valid !== 1'b1 && n < 10);
    verify("first_valid_latency", W'(n), W'(3));
  endtask

  task automatic check_reset_outputs(input string tag);
    verify({tag, "_imem_req"},    W'(bus.imem_req),    '0);
    verify({tag, "_imem_addr"},   bus.imem_addr,       '0);
    verify({tag, "_instr_valid"}, W'(bus.instr_valid), '0);
    verify({tag, "_instr_out"},   W'(bus.instr_out),   '0);
    verify({tag, "_pc_out"},      bus.pc_out,          '0);
`ifdef FETCH_PERF_CNT_EN
    verify({tag, "_fetch_cnt"},   fetch_cnt,           '0);
    verify({tag, "_stall_cnt"},   stall_cnt,           '0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_pc     = '0;
    bus.branch_offset = '0;
    rst_n             = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // sequential fetch 0,4,8
    exp_addr_q.push_back(W'(0)); exp_addr_q.push_back(W'(4)); exp_addr_q.push_back(W'(8));
    exp_pc_q.push_back(W'(0));   exp_pc_q.push_back(W'(4));   exp_pc_q.push_back(W'(8));
    rst_n = 1'b1;
    measure_latency();
    wait_valid(W'(4), 10);
    wait_valid(W'(8), 10);

    // redirect coincident with handshake at pc 8: 0x10 + (8<<2) = 0x30, not 0xC
    exp_addr_q.push_back(W'(64'h30)); exp_pc_q.push_back(W'(64'h30));
    pulse_branch(W'(64'h10), W'(8));
    verify("redirect_hs_addr", bus.imem_addr, W'(64'h30));
    wait_valid(W'(64'h30), 10);

    // stall 4 cycles in VALID
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      verify("stall_valid",     W'(bus.instr_valid), W'(1));
      verify("stall_pc_out",    bus.pc_out,          W'(64'h30));
      verify("stall_instr_out", W'(bus.instr_out),   W'(instr_of(W'(64'h30))));
      verify("stall_no_req",    W'(bus.imem_req),    '0);
      verify("stall_pc",        bus.imem_addr,       W'(64'h30));
    end
    exp_addr_q.push_back(W'(64'h34));
    bus.instr_ready = 1'b1;
    wait_valid(W'(64'h34), 10);

    // redirect from VALID without handshake: 0x20 + (-5<<2) = 0x0C, 0x34 dropped
    bus.instr_ready = 1'b0;
    exp_addr_q.push_back(W'(64'h0C)); exp_pc_q.push_back(W'(64'h0C));
    pulse_branch(W'(64'h20), 64'hFFFF_FFFF_FFFF_FFFB);
    verify("redirect_drops_valid", W'(bus.instr_valid), '0);
    bus.instr_ready = 1'b1;
    wait_valid(W'(64'h0C), 10);

    // redirect in WAIT with slow memory: stale 0x10 response drained
    exp_addr_q.push_back(W'(64'h10));
    lat = 3;
    wait_req(W'(64'h10), 10);
    tick();
    exp_addr_q.push_back(W'(64'h40)); exp_pc_q.push_back(W'(64'h40));
    pulse_branch(W'(64'h30), W'(4));
    lat = 1;
    wait_valid(W'(64'h40), 20);

    // redirect in REQ as the request issues: B 64 from 0 -> 0x100
    exp_addr_q.push_back(W'(64'h44));
    wait_req(W'(64'h44), 10);
    exp_addr_q.push_back(W'(64'h100)); exp_pc_q.push_back(W'(64'h100));
    pulse_branch(W'(0), W'(64));
    wait_valid(W'(64'h100), 20);

    // offset top bits discarded, then pc+4 wraps to 0
    exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_pc_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_addr_q.push_back(W'(0));                   exp_pc_q.push_back(W'(0));
    pulse_branch(64'hFFFF_FFFF_FFFF_FFF8, 64'hC000_0000_0000_0001);
    wait_valid(64'hFFFF_FFFF_FFFF_FFFC, 10);
    wait_valid(W'(0), 10);

    // reset pulse during WAIT, stale response lands after release
    exp_addr_q.push_back(W'(4));
    lat = 3;
    wait_req(W'(4), 10);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    exp_addr_q.push_back(W'(0)); exp_pc_q.push_back(W'(0));
    rst_n = 1'b1;
    lat   = 1;
    measure_latency();
    verify("refetch_pc_out", bus.pc_out, W'(0));
    exp_addr_q.push_back(W'(4));
    tick();
    bus.instr_ready = 1'b0;
    wait_valid(W'(4), 10);
`ifdef FETCH_PERF_CNT_EN
    verify("fetch_cnt", fetch_cnt, W'(1));
    tick(); tick();
    verify("stall_cnt", stall_cnt, W'(2));
`endif
    tick();
    verify("req_queue_drained",   W'(exp_addr_q.size()), '0);
    verify("instr_queue_drained", W'(exp_pc_q.size()),   '0);

    final_result();
    $finish;
  end

endmodule
